// File: rtl/freq_analyzer.sv
// freq_analyzer: finds the strongest of 16 FFT bins in one frame.
//
// A rising edge of fft_valid in IDLE copies all 16 bins into a frame bank.
// SCAN then walks the bank one bin per cycle for 16 cycles and keeps a
// running maximum of re^2 + im^2. On the final scan edge the winning index
// and magnitude are registered and done pulses while in REPORT.
//
// Handshake: fft_valid is a level. A frame starts only on its rising edge
// (sampled 1, previous sample 0) while IDLE. A rising edge seen while busy
// is dropped, and it is not replayed later. There is no backpressure; busy
// is informational only.
//
// Ports:
//   clk                  rising-edge clock
//   rst                  asynchronous reset, active low
//   fft_valid            frame-ready level from the FFT stage
//   fft_d0..fft_d15      bin k: [31:16] signed real, [15:0] signed imag
//   done                 one-cycle pulse when a result is published
//   freq                 index of the strongest bin (held until next done)
//   mag                  unsigned re^2+im^2 of that bin (held until next done)
//   busy                 high in SCAN and REPORT
//   dbg_state            current FSM state (0 IDLE, 1 SCAN, 2 REPORT)
module freq_analyzer #(
  parameter bit TIE_HIGHER = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  output logic        done,
  output logic [3:0]  freq,
  output logic [31:0] mag,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] max_q, max_d;
  logic [3:0]  max_idx_q, max_idx_d;
  logic        vld_prev_q, vld_prev_d;
  logic        done_q, done_d;
  logic [3:0]  freq_q, freq_d;
  logic [31:0] mag_q, mag_d;
  logic        busy_q, busy_d;
  logic [31:0] bank_q [16];
  logic [31:0] bank_d [16];
  logic [31:0] din    [16];

  logic               frame_start;
  logic [31:0]        cur_word;
  logic signed [15:0] cur_re, cur_im;
  logic signed [31:0] re_sq, im_sq;
  logic [31:0]        cur_mag;
  logic               replace;
  logic [31:0]        new_max;
  logic [3:0]         new_idx;

  always_comb begin
    din[0]  = fft_d0;  din[1]  = fft_d1;  din[2]  = fft_d2;  din[3]  = fft_d3;
    din[4]  = fft_d4;  din[5]  = fft_d5;  din[6]  = fft_d6;  din[7]  = fft_d7;
    din[8]  = fft_d8;  din[9]  = fft_d9;  din[10] = fft_d10; din[11] = fft_d11;
    din[12] = fft_d12; din[13] = fft_d13; din[14] = fft_d14; din[15] = fft_d15;
  end

  assign frame_start = fft_valid & ~vld_prev_q;

  // Magnitude of the bin under the scan index. Each square is at most 2^30,
  // so the sum (at most 2^31) always fits the unsigned 32-bit result.
  assign cur_word = bank_q[idx_q];
  assign cur_re   = $signed(cur_word[31:16]);
  assign cur_im   = $signed(cur_word[15:0]);
  assign re_sq    = cur_re * cur_re;
  assign im_sq    = cur_im * cur_im;
  assign cur_mag  = $unsigned(re_sq) + $unsigned(im_sq);

  // Bin 0 always seeds the running max; later bins apply the tie rule.
  always_comb begin
    replace = 1'b0;
    if (idx_q == 4'd0) begin
      replace = 1'b1;
    end else if (TIE_HIGHER) begin
      replace = (cur_mag >= max_q);
    end else begin
      replace = (cur_mag > max_q);
    end
    new_max = replace ? cur_mag : max_q;
    new_idx = replace ? idx_q   : max_idx_q;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    max_d      = max_q;
    max_idx_d  = max_idx_q;
    vld_prev_d = fft_valid;  // tracks every cycle, so edges seen while busy are consumed
    done_d     = 1'b0;
    freq_d     = freq_q;
    mag_d      = mag_q;
    busy_d     = busy_q;
    bank_d     = bank_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_SCAN;
          bank_d  = din;
          idx_d   = 4'd0;
          busy_d  = 1'b1;
        end
      end
      S_SCAN: begin
        max_d     = new_max;
        max_idx_d = new_idx;
        idx_d     = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          // Publish on the same edge that folds in bin 15.
          state_d = S_REPORT;
          idx_d   = 4'd0;
          done_d  = 1'b1;
          freq_d  = new_idx;
          mag_d   = new_max;
        end
      end
      S_REPORT: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      max_q      <= 32'd0;
      max_idx_q  <= 4'd0;
      vld_prev_q <= 1'b0;
      done_q     <= 1'b0;
      freq_q     <= 4'd0;
      mag_q      <= 32'd0;
      busy_q     <= 1'b0;
      for (int i = 0; i < 16; i++) bank_q[i] <= 32'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      max_q      <= max_d;
      max_idx_q  <= max_idx_d;
      vld_prev_q <= vld_prev_d;
      done_q     <= done_d;
      freq_q     <= freq_d;
      mag_q      <= mag_d;
      busy_q     <= busy_d;
      bank_q     <= bank_d;
    end
  end

  assign done      = done_q;
  assign freq      = freq_q;
  assign mag       = mag_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_freq_analyzer.sv
// Bench for freq_analyzer: two instances (lowest-index and highest-index tie
// rule) share every input; results are compared against a reference model
// that picks the strongest bin from the captured frame with plain arithmetic.
module tb_freq_analyzer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        fft_valid;
  logic [31:0] din [16];

  logic        done_lo, busy_lo, done_hi, busy_hi;
  logic [3:0]  freq_lo, freq_hi;
  logic [31:0] mag_lo, mag_hi;
  logic [1:0]  st_lo, st_hi;

  int checks = 0;
  int errors = 0;

  // Results of the most recent frame, for directed constant checks.
  logic [3:0]  res_f_lo, res_f_hi;
  logic [31:0] res_m_lo, res_m_hi;

  freq_analyzer #(.TIE_HIGHER(1'b0)) u_dut_lo (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(din[0]),   .fft_d1(din[1]),   .fft_d2(din[2]),   .fft_d3(din[3]),
    .fft_d4(din[4]),   .fft_d5(din[5]),   .fft_d6(din[6]),   .fft_d7(din[7]),
    .fft_d8(din[8]),   .fft_d9(din[9]),   .fft_d10(din[10]), .fft_d11(din[11]),
    .fft_d12(din[12]), .fft_d13(din[13]), .fft_d14(din[14]), .fft_d15(din[15]),
    .done(done_lo), .freq(freq_lo), .mag(mag_lo), .busy(busy_lo), .dbg_state(st_lo)
  );

  freq_analyzer #(.TIE_HIGHER(1'b1)) u_dut_hi (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(din[0]),   .fft_d1(din[1]),   .fft_d2(din[2]),   .fft_d3(din[3]),
    .fft_d4(din[4]),   .fft_d5(din[5]),   .fft_d6(din[6]),   .fft_d7(din[7]),
    .fft_d8(din[8]),   .fft_d9(din[9]),   .fft_d10(din[10]), .fft_d11(din[11]),
    .fft_d12(din[12]), .fft_d13(din[13]), .fft_d14(din[14]), .fft_d15(din[15]),
    .done(done_hi), .freq(freq_hi), .mag(mag_hi), .busy(busy_hi), .dbg_state(st_hi)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: magnitude of every bin as a wide integer, then the first
  // (or last) bin holding the largest value.
  function automatic void model(input logic [31:0] b [16], input bit hi,
                                output logic [3:0] f, output logic [31:0] m);
    longint mags [16];
    longint best;
    int re, im, win;
    best = -1;
    for (int i = 0; i < 16; i++) begin
      re = $signed(b[i][31:16]);
      im = $signed(b[i][15:0]);
      mags[i] = longint'(re) * re + longint'(im) * im;
      if (mags[i] > best) best = mags[i];
    end
    win = 0;
    if (hi) begin
      for (int i = 0; i < 16; i++) if (mags[i] == best) win = i;
    end else begin
      for (int i = 15; i >= 0; i--) if (mags[i] == best) win = i;
    end
    f = 4'(win);
    m = 32'(best);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic fill_const(input logic [31:0] other, input int k1, input logic [31:0] v1,
                            input int k2, input logic [31:0] v2);
    for (int i = 0; i < 16; i++) din[i] = other;
    if (k1 >= 0) din[k1] = v1;
    if (k2 >= 0) din[k2] = v2;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) din[i] = $urandom;
  endtask

  // Few distinct small values, so equal magnitudes (ties) are common.
  task automatic fill_small();
    logic [15:0] sv [4];
    sv[0] = 16'h0000; sv[1] = 16'h0001; sv[2] = 16'hFFFF; sv[3] = 16'h0002;
    for (int i = 0; i < 16; i++)
      din[i] = {sv[$urandom_range(0, 3)], sv[$urandom_range(0, 3)]};
  endtask

  // mode 0: normal pulse, 1: valid held 100 cycles, 2: low/high blip while busy,
  // 3: valid already high coming out of reset (caller set it up).
  task automatic run_frame(input string tag, input int mode);
    logic [31:0] cap [16];
    logic [3:0]  ef_lo, ef_hi, f_lo, f_hi;
    logic [31:0] em_lo, em_hi, m_lo, m_hi;
    int ncyc, dn_lo, dn_hi, dk_lo, dk_hi, bc_lo, bc_hi;
    if (mode != 3) begin
      fft_valid = 1'b0;
      @(negedge clk);
      check({tag, "/idle_busy_lo"}, 32'(busy_lo), 32'd0);
      fft_valid = 1'b1;
    end
    cap = din;
    model(cap, 1'b0, ef_lo, em_lo);
    model(cap, 1'b1, ef_hi, em_hi);
    ncyc = (mode == 1) ? 100 : 40;
    dn_lo = 0; dn_hi = 0; dk_lo = -1; dk_hi = -1; bc_lo = 0; bc_hi = 0;
    f_lo = 4'hx; f_hi = 4'hx; m_lo = 32'hx; m_hi = 32'hx;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (done_lo) begin dn_lo++; if (dk_lo < 0) dk_lo = k; f_lo = freq_lo; m_lo = mag_lo; end
      if (done_hi) begin dn_hi++; if (dk_hi < 0) dk_hi = k; f_hi = freq_hi; m_hi = mag_hi; end
      if (busy_lo) bc_lo++;
      if (busy_hi) bc_hi++;
      if (k == 3) fill_random();                        // after capture: must not matter
      if ((mode == 0 || mode == 3) && k == 1) fft_valid = 1'b0;
      if (mode == 1 && k == 5) fill_random();
      if (mode == 2 && k == 4) fft_valid = 1'b0;
      if (mode == 2 && k == 5) fft_valid = 1'b1;        // edge while busy: dropped
      if (mode == 2 && k == 10) fft_valid = 1'b0;
    end
    fft_valid = 1'b0;
    check({tag, "/done_cnt_lo"}, 32'(dn_lo), 32'd1);
    check({tag, "/done_cnt_hi"}, 32'(dn_hi), 32'd1);
    check({tag, "/done_cyc_lo"}, 32'(dk_lo), 32'd17);
    check({tag, "/done_cyc_hi"}, 32'(dk_hi), 32'd17);
    check({tag, "/busy_cyc_lo"}, 32'(bc_lo), 32'd17);
    check({tag, "/busy_cyc_hi"}, 32'(bc_hi), 32'd17);
    check({tag, "/freq_lo"}, 32'(f_lo), 32'(ef_lo));
    check({tag, "/mag_lo"}, m_lo, em_lo);
    check({tag, "/freq_hi"}, 32'(f_hi), 32'(ef_hi));
    check({tag, "/mag_hi"}, m_hi, em_hi);
    check({tag, "/hold_freq_lo"}, 32'(freq_lo), 32'(ef_lo));
    check({tag, "/hold_mag_hi"}, mag_hi, em_hi);
    res_f_lo = f_lo; res_f_hi = f_hi; res_m_lo = m_lo; res_m_hi = m_hi;
  endtask

  task automatic mid_scan_reset();
    int dn, bc;
    fft_valid = 1'b0;
    @(negedge clk);
    fft_valid = 1'b1;
    fill_random();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) fft_valid = 1'b0;
    end
    check("msr/busy_before", 32'(busy_lo), 32'd1);
    rst = 1'b0;
    #1;
    check("msr/busy_lo", 32'(busy_lo), 32'd0);
    check("msr/busy_hi", 32'(busy_hi), 32'd0);
    check("msr/freq_lo", 32'(freq_lo), 32'd0);
    check("msr/freq_hi", 32'(freq_hi), 32'd0);
    check("msr/mag_lo", mag_lo, 32'd0);
    check("msr/mag_hi", mag_hi, 32'd0);
    check("msr/state_lo", 32'(st_lo), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    dn = 0; bc = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done_lo || done_hi) dn++;
      if (busy_lo || busy_hi) bc++;
    end
    check("msr/no_done", 32'(dn), 32'd0);
    check("msr/no_busy", 32'(bc), 32'd0);
    check("msr/freq_after", 32'(freq_lo), 32'd0);
    check("msr/mag_after", mag_hi, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0;
    fft_valid = 1'b0;
    fill_const(32'd0, -1, 32'd0, -1, 32'd0);
    repeat (3) @(negedge clk);
    check("rst/done", 32'({done_lo, done_hi}), 32'd0);
    check("rst/busy", 32'({busy_lo, busy_hi}), 32'd0);
    check("rst/freq", 32'({freq_lo, freq_hi}), 32'd0);
    check("rst/mag", mag_lo | mag_hi, 32'd0);

    // Valid already high at the first edge after reset release starts a frame.
    fill_const(32'd0, 5, 32'h0100_0000, -1, 32'd0);
    fft_valid = 1'b1;
    rst = 1'b1;
    run_frame("post_rst_peak", 3);
    check("post_rst_peak/f5", 32'(res_f_lo), 32'd5);
    check("post_rst_peak/m", res_m_lo, 32'h0001_0000);

    fill_const(32'd0, 5, 32'h0100_0000, -1, 32'd0);
    run_frame("peak", 0);
    check("peak/f5_hi", 32'(res_f_hi), 32'd5);

    fill_const(32'h0001_0001, 3, 32'h0003_0004, 12, 32'h0003_0004);
    run_frame("tie", 0);
    check("tie/f_lo3", 32'(res_f_lo), 32'd3);
    check("tie/f_hi12", 32'(res_f_hi), 32'd12);
    check("tie/m25", res_m_hi, 32'd25);

    fill_const(32'd0, -1, 32'd0, -1, 32'd0);
    run_frame("zero", 0);
    check("zero/f_lo0", 32'(res_f_lo), 32'd0);
    check("zero/f_hi15", 32'(res_f_hi), 32'd15);

    fill_const(32'h7FFF_0000, 15, 32'h8000_8000, -1, 32'd0);
    run_frame("extreme", 0);
    check("extreme/f15", 32'(res_f_lo), 32'd15);
    check("extreme/m", res_m_lo, 32'h8000_0000);

    fill_random();
    run_frame("held", 1);

    fill_small();
    run_frame("busy_edge", 2);

    mid_scan_reset();
    fill_const(32'd0, 9, 32'h0000_0200, -1, 32'd0);
    run_frame("after_msr", 0);
    check("after_msr/f9", 32'(res_f_lo), 32'd9);

    for (int r = 0; r < 4; r++) begin
      fill_random();
      run_frame($sformatf("rand%0d", r), 0);
    end
    for (int r = 0; r < 4; r++) begin
      fill_small();
      run_frame($sformatf("small%0d", r), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
